// File: rtl/mpmc11_pkg.sv
// Shared types and constants for the mpmc11 streaming-read scheduler and its arbiter.
package mpmc11_pkg;

   localparam int STRM_BEAT_BYTES = 32;
   localparam int STRM_REMAIN_W   = 32;   // wide enough for any strip-count width up to 32
   localparam int STRM_CREDIT_W   = 16;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN
   } strm_chan_state_t;

   typedef enum logic {
      ARB,
      REQ
   } strm_issue_state_t;

   typedef struct packed {
      logic [31:0]              adr;
      logic [STRM_REMAIN_W-1:0] remain;
      logic [STRM_CREDIT_W-1:0] credit;
      logic [STRM_CREDIT_W-1:0] outstanding;
   } strm_chan_t;

endpackage

// File: rtl/mpmc11_rr_arbiter.sv
// Combinational round-robin arbiter: first set request bit at or after ptr wins.
module mpmc11_rr_arbiter #(
   parameter  int NCH = 4,
   localparam int CHW = $clog2(NCH)
) (
   input  logic [NCH-1:0] req,
   input  logic [CHW-1:0] ptr,
   output logic [NCH-1:0] gnt,
   output logic [CHW-1:0] idx,
   output logic           any
);

   logic [CHW-1:0] cand;

   // NOTE: every signal written here gets a default first, so no path leaves a latch.
   always_comb begin
      gnt  = '0;
      idx  = '0;
      any  = 1'b0;
      cand = '0;
      for (int k = 0; k < NCH; k++) begin
         cand = CHW'((int'(ptr) + k) % NCH);
         if (!any && req[cand]) begin
            any       = 1'b1;
            gnt[cand] = 1'b1;
            idx       = cand;
         end
      end
   end

endmodule

// File: rtl/mpmc11_strm_read_sched.sv
// Credit-gated round-robin strip-read issuer for NCH stream channels.
// Optional feature: define MPMC11_STRM_ABORT_EN to add the per-channel abort input.
module mpmc11_strm_read_sched
   import mpmc11_pkg::*;
#(
   parameter  int NCH         = 4,
   parameter  int STRIP_BEATS = 16,
   parameter  int FIFO_DEPTH  = 256,
   parameter  int CNTW        = 16,
   localparam int CHW         = $clog2(NCH)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NCH-1:0]      start,
   input  logic [NCH*32-1:0]   base_adr,
   input  logic [NCH*CNTW-1:0] nstrips,
   input  logic [NCH-1:0]      pop,
`ifdef MPMC11_STRM_ABORT_EN
   input  logic [NCH-1:0]      abort,
`endif
   output logic                req_valid,
   input  logic                req_ready,
   output logic [31:0]         req_adr,
   output logic [CHW-1:0]      req_ch,
   output logic                req_last_strip,
   input  logic                rtn_beat,
   input  logic [CHW-1:0]      rtn_ch,
   output logic [NCH-1:0]      busy,
   output logic [NCH-1:0]      done,
   output logic                err
);

   localparam logic [31:0]              ADR_STEP   = 32'(STRIP_BEATS * STRM_BEAT_BYTES);
   localparam logic [STRM_CREDIT_W-1:0] CR_STRIP   = STRM_CREDIT_W'(STRIP_BEATS);
   localparam logic [STRM_CREDIT_W-1:0] CR_DEPTH   = STRM_CREDIT_W'(FIFO_DEPTH);
   localparam logic [STRM_CREDIT_W-1:0] CR_ONE     = STRM_CREDIT_W'(1);
   localparam logic [STRM_REMAIN_W-1:0] REMAIN_ONE = STRM_REMAIN_W'(1);

   strm_chan_state_t  cst_q  [NCH];
   strm_chan_state_t  cst_d  [NCH];
   strm_chan_t        chan_q [NCH];
   strm_chan_t        chan_d [NCH];
   strm_issue_state_t iss_q, iss_d;

   logic [CHW-1:0] ptr_q, ptr_d;
   logic           req_valid_d, req_last_d, err_d;
   logic [31:0]    req_adr_d;
   logic [CHW-1:0] req_ch_d;
   logic [NCH-1:0] acc_vec, rtn_vec, pend_vec, elig, arb_gnt;
   logic [CHW-1:0] arb_idx;
   logic           arb_any;

   // A channel with a request still in REQ must not finish, even after an abort.
   always_comb begin
      acc_vec  = '0;
      rtn_vec  = '0;
      pend_vec = '0;
      elig     = '0;
      busy     = '0;
      for (int i = 0; i < NCH; i++) begin
         pend_vec[i] = req_valid && (req_ch == CHW'(i));
         acc_vec[i]  = pend_vec[i] && req_ready;
         rtn_vec[i]  = rtn_beat && (rtn_ch == CHW'(i));
         elig[i]     = (cst_q[i] == RUN) && (chan_q[i].remain != '0)
                       && (chan_q[i].credit >= CR_STRIP);
         busy[i]     = (cst_q[i] != IDLE);
      end
   end

   mpmc11_rr_arbiter #(.NCH(NCH)) u_arb (
      .req (elig),
      .ptr (ptr_q),
      .gnt (arb_gnt),
      .idx (arb_idx),
      .any (arb_any)
   );

   // Per-channel counters and state; pop, accept and return all land in the same cycle.
   always_comb begin
      chan_d = chan_q;
      cst_d  = cst_q;
      done   = '0;
      err_d  = err;
      for (int i = 0; i < NCH; i++) begin
         if (acc_vec[i]) begin
            chan_d[i].adr         = chan_q[i].adr + ADR_STEP;
            chan_d[i].credit      = chan_q[i].credit - CR_STRIP;
            chan_d[i].outstanding = chan_q[i].outstanding + CR_STRIP;
            if (chan_q[i].remain != '0)
               chan_d[i].remain = chan_q[i].remain - REMAIN_ONE;
         end
         if (pop[i] && (chan_d[i].credit != CR_DEPTH))
            chan_d[i].credit = chan_d[i].credit + CR_ONE;
         if (rtn_vec[i]) begin
            if (chan_q[i].outstanding == '0)
               err_d = 1'b1;
            else
               chan_d[i].outstanding = chan_d[i].outstanding - CR_ONE;
         end
         case (cst_q[i])
            IDLE: if (start[i]) begin
               cst_d[i]         = RUN;
               chan_d[i].adr    = base_adr[i*32 +: 32];
               chan_d[i].remain = STRM_REMAIN_W'(nstrips[i*CNTW +: CNTW]);
            end
            RUN: begin
               if (chan_q[i].remain == '0)
                  cst_d[i] = DRAIN;
`ifdef MPMC11_STRM_ABORT_EN
               if (abort[i]) begin
                  chan_d[i].remain = '0;
                  cst_d[i]         = DRAIN;
               end
`endif
            end
            DRAIN: if ((chan_q[i].outstanding == '0) && !pend_vec[i]) begin
               cst_d[i] = IDLE;
               done[i]  = 1'b1;
            end
            default: cst_d[i] = IDLE;
         endcase
      end
   end

   // Issue FSM: request fields are captured at grant and held until accepted.
   always_comb begin
      iss_d       = iss_q;
      ptr_d       = ptr_q;
      req_valid_d = req_valid;
      req_adr_d   = req_adr;
      req_ch_d    = req_ch;
      req_last_d  = req_last_strip;
      case (iss_q)
         ARB: if (arb_any) begin
            iss_d       = REQ;
            req_valid_d = 1'b1;
            req_ch_d    = arb_idx;
            for (int i = 0; i < NCH; i++) begin
               if (arb_gnt[i]) begin
                  req_adr_d  = chan_q[i].adr;
                  req_last_d = (chan_q[i].remain == REMAIN_ONE);
               end
            end
         end
         REQ: if (req_ready) begin
            iss_d       = ARB;
            req_valid_d = 1'b0;
            ptr_d       = (req_ch == CHW'(NCH - 1)) ? '0 : req_ch + CHW'(1);
         end
         default: iss_d = ARB;
      endcase
   end

   // NOTE: state registers use non-blocking assignments only; the per-channel
   // array is a handful of flops rather than a RAM, so it is reset like any register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NCH; i++) begin
            cst_q[i]  <= IDLE;
            chan_q[i] <= '{adr: '0, remain: '0, credit: CR_DEPTH, outstanding: '0};
         end
         iss_q          <= ARB;
         ptr_q          <= '0;
         req_valid      <= 1'b0;
         req_adr        <= '0;
         req_ch         <= '0;
         req_last_strip <= 1'b0;
         err            <= 1'b0;
      end else begin
         cst_q          <= cst_d;
         chan_q         <= chan_d;
         iss_q          <= iss_d;
         ptr_q          <= ptr_d;
         req_valid      <= req_valid_d;
         req_adr        <= req_adr_d;
         req_ch         <= req_ch_d;
         req_last_strip <= req_last_d;
         err            <= err_d;
      end
   end

endmodule

// File: tb/tb_mpmc11_strm_read_sched.sv
// Directed self-checking bench for mpmc11_strm_read_sched (default build, no abort port).
module tb_mpmc11_strm_read_sched;

   localparam int NCH  = 4;
   localparam int CNTW = 16;
   localparam int CHW  = 2;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic [NCH-1:0]      start = '0;
   logic [NCH*32-1:0]   base_adr = '0;
   logic [NCH*CNTW-1:0] nstrips = '0;
   logic [NCH-1:0]      pop = '0;
   logic                req_valid;
   logic                req_ready = 1'b0;
   logic [31:0]         req_adr;
   logic [CHW-1:0]      req_ch;
   logic                req_last_strip;
   logic                rtn_beat = 1'b0;
   logic [CHW-1:0]      rtn_ch = '0;
   logic [NCH-1:0]      busy;
   logic [NCH-1:0]      done;
   logic                err;

   always #5 clk = ~clk;

   mpmc11_strm_read_sched #(
      .NCH(NCH), .STRIP_BEATS(16), .FIFO_DEPTH(256), .CNTW(CNTW)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (start),
      .base_adr       (base_adr),
      .nstrips        (nstrips),
      .pop            (pop),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_adr        (req_adr),
      .req_ch         (req_ch),
      .req_last_strip (req_last_strip),
      .rtn_beat       (rtn_beat),
      .rtn_ch         (rtn_ch),
      .busy           (busy),
      .done           (done),
      .err            (err)
   );

   int             n_chk = 0;
   int             n_err = 0;
   int             cyc = 0;
   int             n_acc = 0;
   int             n_rtn = 0;
   int             last_rtn_cyc = 0;
   logic [31:0]    acc_adr  [64];
   logic [CHW-1:0] acc_ch   [64];
   logic           acc_last [64];
   int             acc_cyc  [64];
   int             done_cnt [NCH];
   int             done_cyc [NCH];
   logic [CHW-1:0] rtn_q [$];
   bit             auto_rtn = 1'b0;
   int             c_start;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic set_chan(input int ch, input logic [31:0] base, input logic [CNTW-1:0] n);
      base_adr[ch*32 +: 32]   = base;
      nstrips[ch*CNTW +: CNTW] = n;
   endtask

   // Called at a falling edge: log what the coming rising edge will do, feed returns, advance.
   task automatic step();
      logic acc_now;
      acc_now = req_valid && req_ready;
      if (acc_now) begin
         if (n_acc < 64) begin
            acc_adr[n_acc]  = req_adr;
            acc_ch[n_acc]   = req_ch;
            acc_last[n_acc] = req_last_strip;
            acc_cyc[n_acc]  = cyc;
         end
         n_acc++;
      end
      for (int i = 0; i < NCH; i++) begin
         if (done[i]) begin
            done_cnt[i]++;
            done_cyc[i] = cyc;
         end
      end
      if (auto_rtn) begin
         if (rtn_q.size() != 0) begin
            rtn_ch       = rtn_q.pop_front();
            rtn_beat     = 1'b1;
            last_rtn_cyc = cyc;
            n_rtn++;
         end else begin
            rtn_beat = 1'b0;
         end
         if (acc_now) repeat (16) rtn_q.push_back(req_ch);
      end
      @(negedge clk);
      cyc++;
   endtask

   task automatic apply_reset();
      rst_n     = 1'b0;
      start     = '0;
      pop       = '0;
      rtn_beat  = 1'b0;
      rtn_ch    = '0;
      req_ready = 1'b0;
      base_adr  = '0;
      nstrips   = '0;
      rtn_q.delete();
      n_acc = 0;
      n_rtn = 0;
      for (int i = 0; i < NCH; i++) done_cnt[i] = 0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic wait_done(input int ch, input int budget, input string tag);
      int k = 0;
      while (done_cnt[ch] == 0 && k < budget) begin
         step();
         k++;
      end
      check({tag, " done seen"}, 32'(done_cnt[ch] != 0), 1);
   endtask

   task automatic wait_valid(input int budget, input string tag);
      int k = 0;
      while (!req_valid && k < budget) begin
         step();
         k++;
      end
      check({tag, " req_valid seen"}, req_valid, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      @(negedge clk);
      apply_reset();
      check("rst req_valid", req_valid, 0);
      check("rst req_adr", req_adr, 0);
      check("rst req_ch", req_ch, 0);
      check("rst req_last_strip", req_last_strip, 0);
      check("rst busy", busy, 0);
      check("rst done", done, 0);
      check("rst err", err, 0);

      // 1: single channel, three strips, immediate returns
      auto_rtn  = 1'b1;
      req_ready = 1'b1;
      set_chan(0, 32'h0000_1000, 3);
      start   = 4'b0001;
      c_start = cyc;
      step();
      start = '0;
      wait_done(0, 300, "t1");
      check("t1 n_req", n_acc, 3);
      check("t1 first accept latency", acc_cyc[0] - c_start, 2);
      check("t1 accept spacing", acc_cyc[1] - acc_cyc[0], 2);
      check("t1 adr0", acc_adr[0], 32'h0000_1000);
      check("t1 adr1", acc_adr[1], 32'h0000_1200);
      check("t1 adr2", acc_adr[2], 32'h0000_1400);
      check("t1 last0", acc_last[0], 0);
      check("t1 last1", acc_last[1], 0);
      check("t1 last2", acc_last[2], 1);
      check("t1 ch2", acc_ch[2], 0);
      check("t1 beats returned", n_rtn, 48);
      check("t1 done after last beat", done_cyc[0], last_rtn_cyc + 1);
      step();
      check("t1 busy cleared", busy[0], 0);
      check("t1 single done", done_cnt[0], 1);

      // 2: four channels start together, round-robin from pointer 0
      apply_reset();
      auto_rtn  = 1'b1;
      req_ready = 1'b1;
      for (int i = 0; i < NCH; i++) set_chan(i, 32'h0001_0000 * (i + 1), 2);
      start = 4'b1111;
      step();
      start = '0;
      wait_done(3, 600, "t2");
      check("t2 n_req", n_acc, 8);
      for (int k = 0; k < 8; k++) begin
         check($sformatf("t2 ch%0d", k), acc_ch[k], k % 4);
         check($sformatf("t2 adr%0d", k), acc_adr[k],
               32'h0001_0000 * ((k % 4) + 1) + 32'h200 * (k / 4));
         check($sformatf("t2 last%0d", k), acc_last[k], 32'(k >= 4));
      end
      for (int i = 0; i < NCH; i++) check($sformatf("t2 done_cnt%0d", i), done_cnt[i], 1);

      // 3: credit gating; surplus pops while full must not add credit
      apply_reset();
      auto_rtn  = 1'b1;
      req_ready = 1'b1;
      pop = 4'b0010;
      repeat (16) step();
      pop = '0;
      set_chan(1, 32'h0002_0000, 20);
      start = 4'b0010;
      step();
      start = '0;
      repeat (100) step();
      check("t3 n_req at zero credit", n_acc, 16);
      check("t3 stalled", req_valid, 0);
      check("t3 busy", busy[1], 1);
      pop = 4'b0010;
      repeat (16) step();
      pop = '0;
      repeat (8) step();
      check("t3 n_req after pops", n_acc, 17);
      check("t3 adr16", acc_adr[16], 32'h0002_2000);
      check("t3 ch16", acc_ch[16], 1);
      check("t3 last16", acc_last[16], 0);
      repeat (20) step();
      check("t3 stalled again", n_acc, 17);

      // 4: back-pressure holds the request stable
      apply_reset();
      auto_rtn = 1'b0;
      set_chan(2, 32'h0000_8000, 2);
      start = 4'b0100;
      step();
      start = '0;
      wait_valid(10, "t4");
      for (int k = 0; k < 5; k++) begin
         check($sformatf("t4 hold%0d valid", k), req_valid, 1);
         check($sformatf("t4 hold%0d adr", k), req_adr, 32'h0000_8000);
         check($sformatf("t4 hold%0d ch", k), req_ch, 2);
         check($sformatf("t4 hold%0d last", k), req_last_strip, 0);
         step();
      end
      req_ready = 1'b1;
      step();
      req_ready = 1'b0;
      check("t4 valid drops after accept", req_valid, 0);
      step();
      check("t4 next valid", req_valid, 1);
      check("t4 next adr", req_adr, 32'h0000_8200);
      check("t4 next last", req_last_strip, 1);
      check("t4 one accept", n_acc, 1);

      // 5: address wrap, start while busy ignored, zero-strip stream
      apply_reset();
      auto_rtn  = 1'b1;
      req_ready = 1'b1;
      set_chan(0, 32'hFFFF_FE00, 2);
      start = 4'b0001;
      step();
      start = '0;
      for (int k = 0; k < 10 && n_acc == 0; k++) step();
      set_chan(0, 32'h0000_5000, 7);
      start = 4'b0001;
      step();
      start = '0;
      wait_done(0, 200, "t5");
      check("t5 n_req", n_acc, 2);
      check("t5 adr0", acc_adr[0], 32'hFFFF_FE00);
      check("t5 adr1 wraps", acc_adr[1], 32'h0000_0000);
      check("t5 last1", acc_last[1], 1);
      step();
      set_chan(3, 32'h0000_4000, 0);
      start = 4'b1000;
      step();
      start = '0;
      check("t5 zero busy", busy[3], 1);
      check("t5 zero done +1", done[3], 0);
      step();
      check("t5 zero done +2", done[3], 1);
      step();
      check("t5 zero done +3", done[3], 0);
      check("t5 zero idle", busy[3], 0);
      check("t5 zero no request", n_acc, 2);

      // 6: asynchronous reset during REQ, then a stray return beat
      apply_reset();
      auto_rtn = 1'b0;
      set_chan(0, 32'h0000_3000, 1);
      start = 4'b0001;
      step();
      start = '0;
      wait_valid(10, "t6");
      check("t6 last strip", req_last_strip, 1);
      #2 rst_n = 1'b0;
      #1;
      check("t6 async valid", req_valid, 0);
      check("t6 async busy", busy, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      for (int i = 0; i < NCH; i++)
         check($sformatf("t6 credit%0d", i), 32'(dut.chan_q[i].credit), 256);
      check("t6 busy", busy, 0);
      check("t6 err clear", err, 0);
      check("t6 no request", req_valid, 0);
      rtn_ch   = 2'd2;
      rtn_beat = 1'b1;
      step();
      rtn_beat = 1'b0;
      check("t6 err set", err, 1);
      repeat (3) step();
      check("t6 err sticky", err, 1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
